// File: rtl/vend_pay_fsm.sv
// Payment controller for the vending machine: accumulates coins against the selected
// product price, vends on confirm, refunds on cancel/timeout and keeps sold counters.
module vend_pay_fsm #(
    parameter logic [3:0]  PRICE1      = 4'd3,
    parameter logic [3:0]  PRICE2      = 4'd5,
    parameter logic [3:0]  PRICE3      = 4'd7,
    parameter logic [3:0]  PRICE4      = 4'd9,
    parameter int unsigned TIMEOUT_CYC = 500_000_000,
    parameter int unsigned HOLD_CYC    = 200_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sel,
    input  logic [15:0] stock,
    input  logic [4:0]  bt_edge,
    output logic [3:0]  remain,
    output logic [3:0]  credit,
    output logic [3:0]  back,
    output logic [15:0] count,
    output logic [2:0]  state,
    output logic        vend_pulse,
    output logic        err_pulse
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3,
        REFUND   = 3'd4
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYC - 1);

    state_t      cur_q, cur_d;
    logic [1:0]  prod_q, prod_d;
    logic [3:0]  credit_q, credit_d;
    logic [3:0]  back_q, back_d;
    logic [3:0]  remain_q, remain_d;
    logic [15:0] count_q, count_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] hold_q, hold_d;
    logic [3:0]  err_sel_q, err_sel_d;
    logic        vend_q, vend_d;
    logic        err_q, err_d;

    // Product index 0..3 maps to prod1..prod4, matching the {S1,S2,S3,S4} select order.
    function automatic logic [3:0] price_of(input logic [1:0] p);
        logic [3:0] r;
        case (p)
            2'd0:    r = PRICE1;
            2'd1:    r = PRICE2;
            2'd2:    r = PRICE3;
            default: r = PRICE4;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] p);
        logic [3:0] r;
        case (p)
            2'd0:    r = v[15:12];
            2'd1:    r = v[11:8];
            2'd2:    r = v[7:4];
            default: r = v[3:0];
        endcase
        return r;
    endfunction

    function automatic logic [3:0] sub_sat(input logic [3:0] a, input logic [3:0] b);
        return (b >= a) ? 4'd0 : a - b;
    endfunction

    function automatic logic [3:0] inc_sat(input logic [3:0] a);
        return (a == 4'd15) ? a : a + 4'd1;
    endfunction

    logic       sel_valid;
    logic [1:0] sel_idx;
    logic [3:0] latched_sel;
    logic [2:0] coin_bits;
    logic       coin_any;
    logic       coin_multi;
    logic [3:0] coin_val;
    logic [4:0] coin_sum;
    logic       coin_accept;

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (sel)
            4'b1000: sel_idx = 2'd0;
            4'b0100: sel_idx = 2'd1;
            4'b0010: sel_idx = 2'd2;
            4'b0001: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase
    end

    assign latched_sel = 4'b1000 >> prod_q;
    assign coin_bits   = bt_edge[2:0];
    assign coin_any    = |coin_bits;
    assign coin_multi  = (coin_bits & (coin_bits - 3'd1)) != 3'd0;

    always_comb begin
        case (coin_bits)
            3'b001:  coin_val = 4'd1;
            3'b010:  coin_val = 4'd2;
            3'b100:  coin_val = 4'd5;
            default: coin_val = 4'd0;
        endcase
    end

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave
        // one unassigned and infer a latch.
        cur_d       = cur_q;
        prod_d      = prod_q;
        credit_d    = credit_q;
        back_d      = back_q;
        remain_d    = remain_q;
        count_d     = count_q;
        timer_d     = '0;
        hold_d      = '0;
        err_sel_d   = '0;
        vend_d      = 1'b0;
        err_d       = 1'b0;
        coin_accept = 1'b0;

        case (cur_q)
            IDLE: begin
                if (sel_valid) begin
                    if (nibble_of(stock, sel_idx) != 4'd0) begin
                        cur_d    = COLLECT;
                        prod_d   = sel_idx;
                        remain_d = price_of(sel_idx);
                    end else begin
                        // Sold-out is flagged once per selection, not every cycle it is held.
                        err_sel_d = sel;
                        err_d     = (sel != err_sel_q);
                    end
                end
            end

            COLLECT: begin
                if (bt_edge[4]) begin
                    cur_d    = REFUND;
                    back_d   = credit_q;
                    credit_d = '0;
                end else if (bt_edge[3]) begin
                    if (credit_q >= price_of(prod_q) && nibble_of(stock, prod_q) != 4'd0) begin
                        cur_d  = DISPENSE;
                        vend_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (credit_q == 4'd0 && sel != latched_sel) begin
                    if (sel_valid && nibble_of(stock, sel_idx) != 4'd0) begin
                        prod_d   = sel_idx;
                        remain_d = price_of(sel_idx);
                    end else if (sel_valid) begin
                        cur_d     = IDLE;
                        err_d     = 1'b1;
                        err_sel_d = sel;
                    end else begin
                        cur_d = IDLE;
                    end
                end else if (coin_multi) begin
                    err_d = 1'b1;
                end else if (coin_any) begin
                    if (coin_sum > 5'd15) begin
                        err_d = 1'b1;
                    end else begin
                        coin_accept = 1'b1;
                        credit_d    = coin_sum[3:0];
                        remain_d    = sub_sat(price_of(prod_q), coin_sum[3:0]);
                    end
                end

                // Idle timer only runs while money is held; an accepted coin restarts it.
                if (cur_d == COLLECT && credit_q != 4'd0 && !coin_accept) begin
                    if (timer_q == TIMEOUT_LAST) begin
                        cur_d    = REFUND;
                        back_d   = credit_q;
                        credit_d = '0;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
            end

            DISPENSE: begin
                case (prod_q)
                    2'd0:    count_d[15:12] = inc_sat(count_q[15:12]);
                    2'd1:    count_d[11:8]  = inc_sat(count_q[11:8]);
                    2'd2:    count_d[7:4]   = inc_sat(count_q[7:4]);
                    default: count_d[3:0]   = inc_sat(count_q[3:0]);
                endcase
                back_d   = credit_q - price_of(prod_q);
                credit_d = '0;
                cur_d    = CHANGE;
            end

            CHANGE, REFUND: begin
                if (hold_q == HOLD_LAST) begin
                    cur_d  = IDLE;
                    back_d = '0;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end

            default: cur_d = IDLE;
        endcase

        if (cur_d != COLLECT) begin
            remain_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (!rst_n) begin
            cur_q     <= IDLE;
            prod_q    <= '0;
            credit_q  <= '0;
            back_q    <= '0;
            remain_q  <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            hold_q    <= '0;
            err_sel_q <= '0;
            vend_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            prod_q    <= prod_d;
            credit_q  <= credit_d;
            back_q    <= back_d;
            remain_q  <= remain_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            hold_q    <= hold_d;
            err_sel_q <= err_sel_d;
            vend_q    <= vend_d;
            err_q     <= err_d;
        end
    end

    assign state      = cur_q;
    assign remain     = remain_q;
    assign credit     = credit_q;
    assign back       = back_q;
    assign count      = count_q;
    assign vend_pulse = vend_q;
    assign err_pulse  = err_q;

endmodule
